vga_frame_sync: RTL and testbench
=================================

VGA_FRAME_SYNC -- requirements
Module: vga_frame_sync

Interface
REQ-001 Parameter CLK_DIV, default 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); legal range 2..16.
REQ-002 Parameter HD, default 640, visible pixels per line.
REQ-003 Parameters HF/HR/HB, defaults 16/96/48: horizontal front porch, sync width and back porch in pixels.
REQ-004 Parameter VD, default 480, visible lines per frame.
REQ-005 Parameters VF/VR/VB, defaults 10/2/33: vertical front porch, sync width and back porch in lines.
REQ-006 clk  in  1  system clock; the block has one clock, all state on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 pixel_tick  out  1  one-clk pulse marking the last clk of each pixel period.
REQ-009 x  out  11  current pixel column, feeds the pattern/stream cores' x input.
REQ-010 y  out  11  current pixel row, feeds the pattern/stream cores' y input.
REQ-011 hsync  out  1  horizontal sync, active low.
REQ-012 vsync  out  1  vertical sync, active low.
REQ-013 video_on  out  1  high while (x,y) lies in the visible region.
REQ-014 frame_start  out  1  one-clk pulse at the first pixel of each frame.

Function
REQ-015 Divider counter, width 4, counts 0..CLK_DIV-1 and wraps to 0; pixel_tick = 1 iff divider == CLK_DIV-1.
REQ-016 HTOTAL = HD+HF+HR+HB (800); VTOTAL = VD+VF+VR+VB (525).
REQ-017 x advances only on a clk edge where pixel_tick = 1; x = HTOTAL-1 wraps to 0.
REQ-018 y advances only on an edge where pixel_tick = 1 and x = HTOTAL-1; y = VTOTAL-1 wraps to 0.
REQ-019 x, y hold between ticks; each pixel value persists exactly CLK_DIV clk cycles.
REQ-020 hsync = 0 iff HD+HF <= x <= HD+HF+HR-1 (656..751).
REQ-021 vsync = 0 iff VD+VF <= y <= VD+VF+VR-1 (490..491).
REQ-022 video_on = 1 iff x < HD and y < VD.
REQ-023 hsync, vsync and video_on are registered, decoded from next-state counter values, so they change on the same edge as x, y with zero skew.
REQ-024 frame_start = 1 for exactly one clk: the first clk cycle in which x=0, y=0 (after reset or after wrap from (HTOTAL-1, VTOTAL-1)).
REQ-025 Simultaneous x and y wrap at (799,524) produces (0,0) on one edge; there is no intermediate state.
REQ-026 All arithmetic is unsigned, 11-bit; x and y never exceed HTOTAL-1 and VTOTAL-1.

Reset
REQ-027 On reset: divider=0, x=0, y=0, pixel_tick=0, hsync=1, vsync=1, video_on=1.
REQ-028 frame_start is asserted in the first clk after reset deassertion.
REQ-029 Reset asserted mid-line or mid-frame clears state immediately, without waiting for a clock edge, and restarts timing from (0,0).

Configuration
REQ-030 Macro VGA_SYNC_DELAY_EN, when defined, passes hsync and vsync through a 2-clk register pipeline (reset value 1) to align them with 2-stage downstream pixel pipelines; x, y, video_on and frame_start are not delayed.
REQ-031 Without VGA_SYNC_DELAY_EN, hsync and vsync follow REQ-020/REQ-021 with no added delay.

Verification
REQ-032 Release reset, run 4 clks -> pixel_tick high only in clk 4; x goes 0->1 on that edge; frame_start high in clk 1 only.
REQ-033 Run to x=655 -> hsync=1; next tick x=656 -> hsync=0; hold through x=751; x=752 -> hsync=1; 96 pixels low total.
REQ-034 Run a full frame (800*525*4 = 1,680,000 clks) -> vsync low exactly for y=490..491; frame_start pulses once per frame, 1,680,000 clks apart.
REQ-035 At (639,479) video_on=1; at (640,479) and at (0,480) video_on=0; at (799,524)->(0,0) video_on=1 and y wraps on the same edge as x.
REQ-036 Assert reset at (300,200) between clock edges -> outputs return to REQ-027 values before the next edge; restart from (0,0).
REQ-037 With VGA_SYNC_DELAY_EN defined -> hsync falls 2 clks after x changes to 656; without it, on the same edge.

Source files
------------

// File: rtl/vga_frame_sync.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_sync
// Brief    : VGA pixel-clock divider and raster timing generator (x/y, syncs,
//            visible window, frame start). Optional macro VGA_SYNC_DELAY_EN
//            adds a 2-clk delay to hsync/vsync for downstream pixel pipelines.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_sync #(
    parameter int CLK_DIV = 4,
    parameter int HD      = 640,
    parameter int HF      = 16,
    parameter int HR      = 96,
    parameter int HB      = 48,
    parameter int VD      = 480,
    parameter int VF      = 10,
    parameter int VR      = 2,
    parameter int VB      = 33
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pixel_tick,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start
);

    localparam logic [3:0]  c_div_last = 4'(CLK_DIV - 1);
    localparam logic [10:0] c_htotal   = 11'(HD + HF + HR + HB);
    localparam logic [10:0] c_vtotal   = 11'(VD + VF + VR + VB);
    localparam logic [10:0] c_hd       = 11'(HD);
    localparam logic [10:0] c_vd       = 11'(VD);
    localparam logic [10:0] c_hs_start = 11'(HD + HF);
    localparam logic [10:0] c_hs_end   = 11'(HD + HF + HR - 1);
    localparam logic [10:0] c_vs_start = 11'(VD + VF);
    localparam logic [10:0] c_vs_end   = 11'(VD + VF + VR - 1);

    logic [3:0]  r_div;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_video_on;
    logic        w_tick;
    logic [10:0] w_x_nxt;
    logic [10:0] w_y_nxt;

    assign w_tick = (r_div == c_div_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= 4'd0;
        end else if (w_tick) begin
            r_div <= 4'd0;
        end else begin
            r_div <= r_div + 4'd1;
        end
    end

    // Both counters wrap in the same cycle at the frame corner, so (0,0)
    // follows (HTOTAL-1, VTOTAL-1) directly.
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_tick) begin
            if (r_x == c_htotal - 11'd1) begin
                w_x_nxt = 11'd0;
                if (r_y == c_vtotal - 11'd1) begin
                    w_y_nxt = 11'd0;
                end else begin
                    w_y_nxt = r_y + 11'd1;
                end
            end else begin
                w_x_nxt = r_x + 11'd1;
            end
        end
    end

    // Decoding the next-state counters keeps syncs aligned with x/y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x        <= 11'd0;
            r_y        <= 11'd0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b1;
        end else begin
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_hsync    <= !((w_x_nxt >= c_hs_start) && (w_x_nxt <= c_hs_end));
            r_vsync    <= !((w_y_nxt >= c_vs_start) && (w_y_nxt <= c_vs_end));
            r_video_on <= (w_x_nxt < c_hd) && (w_y_nxt < c_vd);
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic [1:0] r_hs_pipe;
    logic [1:0] r_vs_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_pipe <= 2'b11;
            r_vs_pipe <= 2'b11;
        end else begin
            r_hs_pipe <= {r_hs_pipe[0], r_hsync};
            r_vs_pipe <= {r_vs_pipe[0], r_vsync};
        end
    end

    assign hsync = r_hs_pipe[1];
    assign vsync = r_vs_pipe[1];
`else
    assign hsync = r_hsync;
    assign vsync = r_vsync;
`endif

    assign pixel_tick  = w_tick;
    assign x           = r_x;
    assign y           = r_y;
    assign video_on    = r_video_on;
    // First clk of pixel (0,0): after reset or after the frame wrap.
    assign frame_start = (r_div == 4'd0) && (r_x == 11'd0) && (r_y == 11'd0);

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_sync
// Brief    : Directed self-checking bench for vga_frame_sync on a reduced
//            raster (30x17 pixels, 4 clks/pixel) so a full frame is short.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_sync;

    localparam int CLK_DIV = 4;
    localparam int HD = 16, HF = 4, HR = 6, HB = 4;
    localparam int VD = 10, VF = 2, VR = 2, VB = 3;
    localparam int HTOTAL = HD + HF + HR + HB;           // 30
    localparam int VTOTAL = VD + VF + VR + VB;           // 17
    localparam int FRAME_CLKS = HTOTAL * VTOTAL * CLK_DIV; // 2040
`ifdef VGA_SYNC_DELAY_EN
    localparam int SYNC_LAG = 2;
`else
    localparam int SYNC_LAG = 0;
`endif

    logic        clk;
    logic        reset;
    logic        pixel_tick;
    logic [10:0] x;
    logic [10:0] y;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        frame_start;

    int n_checks;
    int n_errors;

    vga_frame_sync #(
        .CLK_DIV(CLK_DIV), .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (pixel_tick),
        .x          (x),
        .y          (y),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Steps negedges until (x,y) reaches the target; an expired budget counts as a failure.
    task automatic wait_xy(input int tx, input int ty, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (x == 11'(tx) && y == 11'(ty)) return;
            @(negedge clk);
        end
        check("wait_xy_timeout", {5'd0, y, 5'd0, x}, {5'd0, 11'(ty), 5'd0, 11'(tx)});
    endtask

    int hs_low, vs_low, von_cnt, fs_cnt, fs_idx;
    int hs_xmin, hs_xmax, vs_ymin, vs_ymax;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_pixel_tick", 32'(pixel_tick), 0);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_video_on", 32'(video_on), 1);

        // Startup: tick in clk 4 only, frame_start in clk 1 only.
        reset = 1'b0;
        for (int k = 1; k <= CLK_DIV; k++) begin
            check($sformatf("start_tick_c%0d", k), 32'(pixel_tick), (k == CLK_DIV) ? 1 : 0);
            check($sformatf("start_fs_c%0d", k), 32'(frame_start), (k == 1) ? 1 : 0);
            check($sformatf("start_x_c%0d", k), 32'(x), 0);
            @(negedge clk);
        end
        check("start_x_after_tick", 32'(x), 1);
        check("start_tick_after", 32'(pixel_tick), 0);

        // Horizontal sync edges around x = 19/20 and 25/26.
        wait_xy(HD + HF - 1, 0, 200);
        check("hs_x19_first", 32'(hsync), 1);
        repeat (CLK_DIV - 1) @(negedge clk);
        check("hs_x19_last", 32'(hsync), 1);
        @(negedge clk);
        check("hs_x20", 32'(x), HD + HF);
        if (SYNC_LAG > 0) begin
            check("hs_x20_before_lag", 32'(hsync), 1);
            repeat (SYNC_LAG) @(negedge clk);
        end
        check("hs_fall", 32'(hsync), 0);
        wait_xy(HD + HF + HR, 0, 200);
        repeat (SYNC_LAG) @(negedge clk);
        check("hs_rise_x26", 32'(hsync), 1);

        // Visible window corners.
        wait_xy(HD - 1, VD - 1, 4000);
        check("von_15_9", 32'(video_on), 1);
        wait_xy(HD, VD - 1, 200);
        check("von_16_9", 32'(video_on), 0);
        wait_xy(0, VD, 400);
        check("von_0_10", 32'(video_on), 0);

        // Frame corner wrap: (29,16) -> (0,0) in one edge.
        wait_xy(HTOTAL - 1, VTOTAL - 1, 4000);
        repeat (CLK_DIV - 1) @(negedge clk);
        check("corner_last_clk_xy", {5'd0, y, 5'd0, x}, {5'd0, 11'(VTOTAL - 1), 5'd0, 11'(HTOTAL - 1)});
        check("corner_fs_low", 32'(frame_start), 0);
        @(negedge clk);
        check("wrap_xy", {5'd0, y, 5'd0, x}, 0);
        check("wrap_video_on", 32'(video_on), 1);
        check("wrap_frame_start", 32'(frame_start), 1);
        @(negedge clk);
        check("wrap_fs_one_clk", 32'(frame_start), 0);

        // Full-frame scan starting on clk 2 of pixel (0,0).
        hs_low = 0; vs_low = 0; von_cnt = 0; fs_cnt = 0; fs_idx = -1;
        hs_xmin = 9999; hs_xmax = -1; vs_ymin = 9999; vs_ymax = -1;
        for (int i = 0; i < FRAME_CLKS; i++) begin
            if (!hsync) begin
                hs_low++;
                if (int'(x) < hs_xmin) hs_xmin = int'(x);
                if (int'(x) > hs_xmax) hs_xmax = int'(x);
            end
            if (!vsync) begin
                vs_low++;
                if (int'(y) < vs_ymin) vs_ymin = int'(y);
                if (int'(y) > vs_ymax) vs_ymax = int'(y);
            end
            if (video_on) von_cnt++;
            if (frame_start) begin
                fs_cnt++;
                fs_idx = i;
            end
            @(negedge clk);
        end
        check("frame_hs_low_clks", hs_low, HR * CLK_DIV * VTOTAL);      // 408
        check("frame_vs_low_clks", vs_low, VR * HTOTAL * CLK_DIV);      // 240
        check("frame_video_on_clks", von_cnt, HD * VD * CLK_DIV);       // 640
        check("frame_fs_count", fs_cnt, 1);
        check("frame_fs_period", fs_idx + 1, FRAME_CLKS);
        check("frame_hs_xmin", hs_xmin, HD + HF);
        check("frame_hs_xmax", hs_xmax, HD + HF + HR - 1 + ((SYNC_LAG > 0) ? 1 : 0));
        check("frame_vs_ymin", vs_ymin, VD + VF);
        check("frame_vs_ymax", vs_ymax, VD + VF + VR - 1 + ((SYNC_LAG > 0) ? 1 : 0));

        // Asynchronous reset mid-line while hsync is low and video is off.
        wait_xy(HD + HF, 5, 4000);
        @(negedge clk);
        check("pre_rst_video_on", 32'(video_on), 0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_x", 32'(x), 0);
        check("async_rst_y", 32'(y), 0);
        check("async_rst_hsync", 32'(hsync), 1);
        check("async_rst_vsync", 32'(vsync), 1);
        check("async_rst_video_on", 32'(video_on), 1);
        check("async_rst_tick", 32'(pixel_tick), 0);
        @(negedge clk);
        reset = 1'b0;
        check("restart_fs", 32'(frame_start), 1);
        repeat (CLK_DIV) @(negedge clk);
        check("restart_x", 32'(x), 1);
        check("restart_fs_low", 32'(frame_start), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
